// File: rtl/rgb_color_fader.sv
// rgb_color_fader
// ---------------------------------------------------------------------------
// Duty-cycle generator for a three-channel RGB PWM driver. By default it
// walks a six-segment colour wheel (R->Y->G->C->B->M->R), ramping one channel
// per segment at a rate set by a prescaler. A host can load a fixed colour
// (STATIC), which holds until a resume strobe restarts the wheel.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-low reset
//   enable       1 = wheel and prescaler advance; 0 = freeze (RUN only)
//   tick_final   prescaler terminal count; one ramp tick every tick_final+1 cycles
//   load         strobe: capture load_red/green/blue (clamped to MAX), enter STATIC
//   load_red     static red duty
//   load_green   static green duty
//   load_blue    static blue duty
//   resume       strobe: leave STATIC, restart wheel at segment 0 (load wins)
//   red_duty     red duty word (registered)
//   green_duty   green duty word (registered)
//   blue_duty    blue duty word (registered)
//   segment      current wheel segment 0..5
//   wrap         one-cycle pulse after segment 5 returns to 0
//   static_mode  1 while in STATIC; this is also the FSM state observation
// ---------------------------------------------------------------------------
module rgb_color_fader #(
    parameter int R          = 8,
    parameter int STEP       = 1,
    parameter int TIMER_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [TIMER_BITS-1:0] tick_final,
    input  logic                  load,
    input  logic [R:0]            load_red,
    input  logic [R:0]            load_green,
    input  logic [R:0]            load_blue,
    input  logic                  resume,
    output logic [R:0]            red_duty,
    output logic [R:0]            green_duty,
    output logic [R:0]            blue_duty,
    output logic [2:0]            segment,
    output logic                  wrap,
    output logic                  static_mode
);

    localparam logic [R:0]   MAX    = {1'b1, {R{1'b0}}};
    localparam logic [R+1:0] MAX_W  = {1'b0, MAX};
    localparam logic [R+1:0] STEP_W = (R+2)'(STEP);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_STATIC = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [R:0]            red_q, red_d;
    logic [R:0]            green_q, green_d;
    logic [R:0]            blue_q, blue_d;
    logic [2:0]            seg_q, seg_d;
    logic                  wrap_q, wrap_d;
    logic [TIMER_BITS-1:0] cnt_q, cnt_d;

    // Ramp datapath: pick the channel owned by the current segment and
    // compute its next value with saturation at 0 / MAX.
    logic [1:0]   ramp_sel;      // 0 = red, 1 = green, 2 = blue
    logic         ramp_up;
    logic [R:0]   ramp_cur;
    logic [R+1:0] ramp_ext;
    logic [R+1:0] ramp_sum;
    logic [R+1:0] ramp_diff;
    logic [R:0]   ramp_new;
    logic         ramp_done;
    logic         tick;

    function automatic logic [R:0] clamp_max(input logic [R:0] v);
        return (v > MAX) ? MAX : v;
    endfunction

    always_comb begin
        ramp_sel = 2'd1;
        ramp_up  = 1'b1;
        case (seg_q)
            3'd0:    begin ramp_sel = 2'd1; ramp_up = 1'b1; end
            3'd1:    begin ramp_sel = 2'd0; ramp_up = 1'b0; end
            3'd2:    begin ramp_sel = 2'd2; ramp_up = 1'b1; end
            3'd3:    begin ramp_sel = 2'd1; ramp_up = 1'b0; end
            3'd4:    begin ramp_sel = 2'd0; ramp_up = 1'b1; end
            3'd5:    begin ramp_sel = 2'd2; ramp_up = 1'b0; end
            default: begin ramp_sel = 2'd1; ramp_up = 1'b1; end
        endcase

        case (ramp_sel)
            2'd0:    ramp_cur = red_q;
            2'd2:    ramp_cur = blue_q;
            default: ramp_cur = green_q;
        endcase

        // One extra bit of headroom so v+STEP never wraps before the clamp.
        ramp_ext  = {1'b0, ramp_cur};
        ramp_sum  = ramp_ext + STEP_W;
        ramp_diff = ramp_ext - STEP_W;

        if (ramp_up) begin
            ramp_new  = (ramp_sum >= MAX_W) ? MAX : ramp_sum[R:0];
            ramp_done = (ramp_new == MAX);
        end else begin
            ramp_new  = (ramp_ext >= STEP_W) ? ramp_diff[R:0] : '0;
            ramp_done = (ramp_new == '0);
        end
    end

    // >= rather than == so lowering tick_final below the running count
    // still produces a tick instead of waiting for a counter wrap.
    assign tick = (cnt_q >= tick_final);

    always_comb begin
        state_d = state_q;
        red_d   = red_q;
        green_d = green_q;
        blue_d  = blue_q;
        seg_d   = seg_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;

        if (load) begin
            red_d   = clamp_max(load_red);
            green_d = clamp_max(load_green);
            blue_d  = clamp_max(load_blue);
            cnt_d   = '0;
            state_d = ST_STATIC;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (enable) begin
                        if (tick) begin
                            cnt_d = '0;
                            case (ramp_sel)
                                2'd0:    red_d   = ramp_new;
                                2'd2:    blue_d  = ramp_new;
                                default: green_d = ramp_new;
                            endcase
                            if (ramp_done) begin
                                if (seg_q == 3'd5) begin
                                    seg_d  = 3'd0;
                                    wrap_d = 1'b1;
                                end else begin
                                    seg_d = seg_q + 3'd1;
                                end
                            end
                        end else begin
                            cnt_d = cnt_q + TIMER_BITS'(1);
                        end
                    end
                end
                ST_STATIC: begin
                    if (resume) begin
                        red_d   = MAX;
                        green_d = '0;
                        blue_d  = '0;
                        seg_d   = 3'd0;
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_RUN;
            red_q   <= MAX;
            green_q <= '0;
            blue_q  <= '0;
            seg_q   <= 3'd0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
            seg_q   <= seg_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
        end
    end

    assign red_duty    = red_q;
    assign green_duty  = green_q;
    assign blue_duty   = blue_q;
    assign segment     = seg_q;
    assign wrap        = wrap_q;
    assign static_mode = (state_q == ST_STATIC);

endmodule
